watch_disp_scan: RTL and testbench

//  Display-side consumer of the watch time counters: takes the BCD hour/minute digits
//  (hour_10, hour1, min_10, min1) and drives a 4-digit multiplexed common-anode 7-segment display.

---
 rtl/watch_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/watch_disp_scan.sv | 103 ++++++++++
 tb/tb_watch_disp_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - segment codes, anode constants and digit-slot type for the watch display
package watch_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [3:0] AN_OFF   = 4'hF;

    // Slot order right to left: minutes units first, hours tens last.
    typedef enum logic [1:0] {
        IDX_MIN1   = 2'd0,
        IDX_MIN10  = 2'd1,
        IDX_HOUR1  = 2'd2,
        IDX_HOUR10 = 2'd3
    } digit_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-high {g..a} segment pattern, non-BCD shows a dash
module bcd_to_seg7
    import watch_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/watch_disp_scan.sv
// rtl/watch_disp_scan.sv - 4-digit multiplexed 7-segment scanner with per-frame snapshot
// Optional build macro: DISP_LZB_EN (blank a leading zero in the hours tens slot).
module watch_disp_scan
    import watch_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_10,
    input  logic [3:0] hour1,
    input  logic [3:0] min_10,
    input  logic [3:0] min1,
    input  logic       colon,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_st
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic [15:0]   snap;
    logic          colon_snap;

    logic          cnt_last;
    logic          blank;
    logic          load;
    logic          suppress;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;
    logic          dp_n;

    assign cnt_last = (cnt == CW'(SCAN_DIV - 1));
    assign blank    = (cnt < CW'(BLANK_CYC));
    assign load     = (cnt == '0) && (idx == IDX_MIN1);

    always_comb begin
        cur_digit = snap[3:0];
        case (idx)
            IDX_MIN1:   cur_digit = snap[3:0];
            IDX_MIN10:  cur_digit = snap[7:4];
            IDX_HOUR1:  cur_digit = snap[11:8];
            IDX_HOUR10: cur_digit = snap[15:12];
            default:    cur_digit = snap[3:0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef DISP_LZB_EN
    assign suppress = (idx == IDX_HOUR10) && (snap[15:12] == 4'd0);
`else
    assign suppress = 1'b0;
`endif

    // Anodes stay off at the head of every slot so the previous digit cannot ghost.
    always_comb begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        dp_n  = 1'b0;
        if (!blank && !suppress) begin
            an_n  = ~(4'b0001 << idx);
            seg_n = dec_seg;
            dp_n  = (idx == IDX_HOUR1) && colon_snap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= IDX_MIN1;
            snap       <= 16'h0;
            colon_snap <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            an         <= AN_OFF;
            frame_st   <= 1'b0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
            if (cnt_last) begin
                idx <= digit_idx_t'(idx + 2'd1);
            end
            if (load) begin
                snap       <= {hour_10, hour1, min_10, min1};
                colon_snap <= colon;
            end
            frame_st <= load;
            seg      <= seg_n;
            dp       <= dp_n;
            an       <= an_n;
        end
    end

endmodule

// File: tb/tb_watch_disp_scan.sv
// tb/tb_watch_disp_scan.sv - directed table-driven bench for watch_disp_scan (SCAN_DIV=8, BLANK_CYC=2)
module tb_watch_disp_scan;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hour_10, hour1, min_10, min1;
    logic       colon;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    watch_disp_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .hour_10  (hour_10),
        .hour1    (hour1),
        .min_10   (min_10),
        .min1     (min1),
        .colon    (colon),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame_st (frame_st)
    );

    typedef struct {
        string      name;
        logic [3:0] h10, h1, m10, m1;
        logic       col;
        int         pos;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic col);
        hour_10 = a; hour1 = b; min_10 = c; min1 = d; colon = col;
    endtask

    // Returns at the negedge on which frame_st is seen high (outputs show frame position 0).
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_st !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (frame_st !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: frame_st timeout got 0 expected 1", name);
        end
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [6:0] s, input logic [3:0] a, input logic d);
        check({name, " seg"}, {9'h0, seg}, {9'h0, s});
        check({name, " an"},  {12'h0, an}, {12'h0, a});
        check({name, " dp"},  {15'h0, dp}, {15'h0, d});
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d, input logic col,
                                input int p, input logic [6:0] s, input logic [3:0] an_e, input logic dp_e);
        vec_t v;
        v.name = nm; v.h10 = a; v.h1 = b; v.m10 = c; v.m1 = d; v.col = col;
        v.pos = p; v.e_seg = s; v.e_an = an_e; v.e_dp = dp_e;
        return v;
    endfunction

    initial begin
        int n;

        vecs.push_back(mk("1234_p0blank",  4'd1, 4'd2, 4'd3, 4'd4, 1'b1,  1, 7'h00, 4'hF, 1'b0));
        vecs.push_back(mk("1234_slot0",    4'd1, 4'd2, 4'd3, 4'd4, 1'b1,  2, 7'h66, 4'hE, 1'b0));
        vecs.push_back(mk("1234_s1blank",  4'd1, 4'd2, 4'd3, 4'd4, 1'b1,  9, 7'h00, 4'hF, 1'b0));
        vecs.push_back(mk("1234_slot1",    4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 10, 7'h4F, 4'hD, 1'b0));
        vecs.push_back(mk("1234_slot2",    4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 18, 7'h5B, 4'hB, 1'b1));
        vecs.push_back(mk("1234_slot2end", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 23, 7'h5B, 4'hB, 1'b1));
        vecs.push_back(mk("1234_slot3",    4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 26, 7'h06, 4'h7, 1'b0));
        vecs.push_back(mk("1234_slot3end", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 31, 7'h06, 4'h7, 1'b0));
        vecs.push_back(mk("nocolon_dp",    4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 18, 7'h5B, 4'hB, 1'b0));
        vecs.push_back(mk("5680_slot0",    4'd5, 4'd6, 4'd8, 4'd0, 1'b0,  2, 7'h3F, 4'hE, 1'b0));
        vecs.push_back(mk("5680_slot1",    4'd5, 4'd6, 4'd8, 4'd0, 1'b0, 10, 7'h7F, 4'hD, 1'b0));
        vecs.push_back(mk("5680_slot2",    4'd5, 4'd6, 4'd8, 4'd0, 1'b0, 18, 7'h7D, 4'hB, 1'b0));
        vecs.push_back(mk("5680_slot3",    4'd5, 4'd6, 4'd8, 4'd0, 1'b0, 26, 7'h6D, 4'h7, 1'b0));
        vecs.push_back(mk("inv_min1",      4'd1, 4'd2, 4'd3, 4'hA, 1'b0,  2, 7'h40, 4'hE, 1'b0));
        vecs.push_back(mk("inv_hour10",    4'hF, 4'd2, 4'd3, 4'd4, 1'b0, 26, 7'h40, 4'h7, 1'b0));
        vecs.push_back(mk("lzb_hour1",     4'd0, 4'd7, 4'd3, 4'd4, 1'b0, 18, 7'h07, 4'hB, 1'b0));
`ifdef DISP_LZB_EN
        vecs.push_back(mk("lzb_slot3",     4'd0, 4'd7, 4'd3, 4'd4, 1'b0, 26, 7'h00, 4'hF, 1'b0));
        vecs.push_back(mk("lzb_slot3end",  4'd0, 4'd7, 4'd3, 4'd4, 1'b0, 31, 7'h00, 4'hF, 1'b0));
`else
        vecs.push_back(mk("lzb_slot3",     4'd0, 4'd7, 4'd3, 4'd4, 1'b0, 26, 7'h3F, 4'h7, 1'b0));
        vecs.push_back(mk("lzb_slot3end",  4'd0, 4'd7, 4'd3, 4'd4, 1'b0, 31, 7'h3F, 4'h7, 1'b0));
`endif

        // Reset held for three clocks
        rst = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        skip(3);
        check_outs("reset", 7'h00, 4'hF, 1'b0);
        check("reset frame_st", {15'h0, frame_st}, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        check("first frame_st", {15'h0, frame_st}, 16'h1);

        // frame_st period
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_st !== 1'b1 && n < 3 * FRAME);
        check("frame period", 16'(n), 16'(FRAME));

        // Table vectors: load inputs, wait for a fresh snapshot, then step to the position
        foreach (vecs[i]) begin
            set_time(vecs[i].h10, vecs[i].h1, vecs[i].m10, vecs[i].m1, vecs[i].col);
            wait_frame(vecs[i].name);
            skip(vecs[i].pos);
            check_outs(vecs[i].name, vecs[i].e_seg, vecs[i].e_an, vecs[i].e_dp);
        end

        // Snapshot coherency: change 09:59 -> 10:00 at idx2 cnt3
        set_time(4'd0, 4'd9, 4'd5, 4'd9, 1'b0);
        wait_frame("snap");
        skip(18);
        set_time(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        skip(2);
        check_outs("snap old slot2", 7'h6F, 4'hB, 1'b0);
        skip(6);
`ifdef DISP_LZB_EN
        check_outs("snap old slot3", 7'h00, 4'hF, 1'b0);
`else
        check_outs("snap old slot3", 7'h3F, 4'h7, 1'b0);
`endif
        wait_frame("snap next");
        skip(2);
        check_outs("snap new slot0", 7'h3F, 4'hE, 1'b0);
        skip(24);
        check_outs("snap new slot3", 7'h06, 4'h7, 1'b0);

        // Reset mid-frame at idx2 cnt5
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        wait_frame("midrst");
        skip(20);
        check_outs("pre-reset slot2", 7'h5B, 4'hB, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_outs("midrst", 7'h00, 4'hF, 1'b0);
        check("midrst frame_st", {15'h0, frame_st}, 16'h0);
        set_time(4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("restart frame_st", {15'h0, frame_st}, 16'h1);
        skip(2);
        check_outs("restart slot0", 7'h6D, 4'hE, 1'b0);
        skip(16);
        check_outs("restart slot2", 7'h4F, 4'hB, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
